// File: rtl/arb_rr.sv
// arb_rr: N-requester round-robin arbiter with registered one-hot grant.
// The last winner is kept as the round-robin pointer and ranks lowest on the
// next arbitration; a release hands off to the next winner with no bubble.
//
// Build option: define ARB_RR_PKT_LOCK_EN to hold each grant for a whole
// packet (release on last beat, requester abort, or beat-budget watchdog).
// Without it, every transfer re-arbitrates, arb_last is ignored and arb_err
// is tied low.
module arb_rr #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  input  logic [N-1:0]         arb_req,
  input  logic [N-1:0]         arb_last,
  input  logic                 dn_rdy,
  output logic [N-1:0]         arb_gnt,
  output logic                 arb_gnt_vld,
  output logic [$clog2(N)-1:0] arb_gnt_id,
  output logic                 arb_err
);

  localparam int IDW = $clog2(N);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_GRANT = 1'b1;

  logic           state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;

  logic           xfer;
  logic           abort;
  logic           rel;
  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] scan_idx;

`ifdef ARB_RR_PKT_LOCK_EN
  localparam int                CW      = $clog2(MAX_BEATS);
  localparam logic [CW-1:0]     CNT_MAX = CW'(MAX_BEATS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          at_max;
  logic          last_hit;
`else
  // arb_last has no meaning when every beat re-arbitrates.
  logic unused_last;
  assign unused_last = ^arb_last;
`endif

  // Round-robin winner: scan from the slot after the pointer, wrapping, so
  // the previous winner is considered last.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = id_q;
    scan_idx = id_q;
    // Walk the ring backwards so the last hit written is the nearest one.
    for (int i = N; i >= 1; i--) begin
      scan_idx = IDW'((int'(id_q) + i) % N);
      if (arb_req[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
    end
  end

  // Release detection and next-state selection for grant, pointer and counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;

    xfer  = state_q & arb_req[id_q] & dn_rdy;
    abort = state_q & ~arb_req[id_q];

`ifdef ARB_RR_PKT_LOCK_EN
    cnt_d    = cnt_q;
    at_max   = (cnt_q == CNT_MAX);
    last_hit = xfer & arb_last[id_q];
    rel      = last_hit | abort | (xfer & at_max);
    // A normal last beat landing on the budget boundary is not an overrun.
    err_d    = xfer & at_max & ~last_hit;
`else
    rel      = xfer | abort;
`endif

    if (state_q == S_IDLE || rel) begin
      if (arb_en && win_vld) begin
        state_d       = S_GRANT;
        id_d          = win_id;
        gnt_d         = '0;
        gnt_d[win_id] = 1'b1;
      end else begin
        // Pointer is deliberately kept so fairness survives an idle gap.
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    end

`ifdef ARB_RR_PKT_LOCK_EN
    if (state_q == S_IDLE || rel) begin
      cnt_d = '0;
    end else if (xfer && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  // Grant state registers; reset drops any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      // Pointer at N-1 makes requester 0 the first winner.
      id_q    <= IDW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
    end
  end

`ifdef ARB_RR_PKT_LOCK_EN
  // Beat counter and one-cycle watchdog error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign arb_err = err_q;
`else
  assign arb_err = 1'b0;
`endif

  assign arb_gnt     = gnt_q;
  assign arb_gnt_vld = state_q;
  assign arb_gnt_id  = id_q;

endmodule

// File: tb/tb_arb_rr.sv
// tb_arb_rr: directed bench for arb_rr with N=4, MAX_BEATS=8.
// The packet-lock sequence runs when ARB_RR_PKT_LOCK_EN is defined, the
// per-beat sequence otherwise; both end with an asynchronous reset check.
module tb_arb_rr;

  logic       clk;
  logic       rst_n;
  logic       arb_en;
  logic [3:0] arb_req;
  logic [3:0] arb_last;
  logic       dn_rdy;
  logic [3:0] arb_gnt;
  logic       arb_gnt_vld;
  logic [1:0] arb_gnt_id;
  logic       arb_err;

  int n_vec  = 0;
  int n_miss = 0;

  arb_rr #(.N(4), .MAX_BEATS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arb_en     (arb_en),
    .arb_req    (arb_req),
    .arb_last   (arb_last),
    .dn_rdy     (dn_rdy),
    .arb_gnt    (arb_gnt),
    .arb_gnt_vld(arb_gnt_vld),
    .arb_gnt_id (arb_gnt_id),
    .arb_err    (arb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] g, input logic v,
                       input logic [1:0] id, input logic e);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {arb_gnt, arb_gnt_vld, arb_gnt_id, arb_err};
    exp = {g, v, id, e};
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: gnt/vld/id/err observed %b_%b_%b_%b expected %b_%b_%b_%b",
             tag, obs[7:4], obs[3], obs[2:1], obs[0], g, v, id, e);
    end
  endtask

  // Expect an active grant to requester id.
  task automatic granted(input string tag, input logic [1:0] id, input logic e);
    check(tag, 4'(1) << id, 1'b1, id, e);
  endtask

  initial begin
    rst_n    = 1'b0;
    arb_en   = 1'b0;
    arb_req  = 4'b0000;
    arb_last = 4'b0000;
    dn_rdy   = 1'b0;
    #12;
    check("reset", 4'b0000, 1'b0, 2'd3, 1'b0);
    rst_n = 1'b1;

`ifdef ARB_RR_PKT_LOCK_EN
    // Full ring, 2-beat packets: 0,1,2,3,0 with no idle cycle.
    arb_en  = 1'b1;
    arb_req = 4'b1111;
    dn_rdy  = 1'b1;
    tick();
    granted("ring_first", 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      arb_last = 4'b0000;
      tick();
      granted("ring_beat1", 2'(k), 1'b0);
      arb_last = 4'b1111;
      tick();
      granted("ring_handoff", 2'((k + 1) % 4), 1'b0);
    end

    // Id 0 ends in one beat; then 1 -> 3 -> 0 -> 1 with req 1011.
    tick();
    granted("skip_to1", 2'd1, 1'b0);
    arb_req  = 4'b1011;
    arb_last = 4'b0010;
    tick();
    granted("skip_to3", 2'd3, 1'b0);
    arb_last = 4'b1000;
    tick();
    granted("skip_to0", 2'd0, 1'b0);
    arb_last = 4'b0001;
    tick();
    granted("skip_to1b", 2'd1, 1'b0);

    // Id 2 stalled five cycles, then three beats with last on the third.
    arb_req  = 4'b0110;
    arb_last = 4'b0010;
    tick();
    granted("stall_gnt2", 2'd2, 1'b0);
    dn_rdy   = 1'b0;
    arb_last = 4'b0000;
    for (int k = 0; k < 5; k++) tick();
    granted("stall_hold", 2'd2, 1'b0);
    dn_rdy = 1'b1;
    tick();
    granted("stall_beat1", 2'd2, 1'b0);
    tick();
    granted("stall_beat2", 2'd2, 1'b0);
    arb_last = 4'b0100;
    tick();
    granted("stall_rel", 2'd1, 1'b0);

    // Id 0 overruns: forced release after beat 8, err pulse, id 1 next.
    arb_req  = 4'b0011;
    arb_last = 4'b0010;
    tick();
    granted("wd_gnt0", 2'd0, 1'b0);
    arb_last = 4'b0000;
    for (int k = 0; k < 7; k++) tick();
    granted("wd_beat7", 2'd0, 1'b0);
    tick();
    granted("wd_forced", 2'd1, 1'b1);
    dn_rdy = 1'b0;
    tick();
    granted("wd_err_clr", 2'd1, 1'b0);

    // Id 1 aborts to id 3; arb_en drops mid-packet; id 3 finishes, IDLE.
    arb_req = 4'b1001;
    tick();
    granted("en_gnt3", 2'd3, 1'b0);
    dn_rdy = 1'b1;
    tick();
    granted("en_beat1", 2'd3, 1'b0);
    arb_en = 1'b0;
    tick();
    granted("en_low_hold", 2'd3, 1'b0);
    arb_last = 4'b1000;
    tick();
    check("en_idle", 4'b0000, 1'b0, 2'd3, 1'b0);
    arb_last = 4'b0000;
    tick();
    check("en_idle_stay", 4'b0000, 1'b0, 2'd3, 1'b0);
    arb_en = 1'b1;
    tick();
    granted("en_regrant", 2'd0, 1'b0);
`else
    // Per-beat: req 0101 alternates 0,2 every cycle; arb_last toggled.
    arb_en  = 1'b1;
    arb_req = 4'b0101;
    dn_rdy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      arb_last = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      granted("alt", (k % 2 == 0) ? 2'd0 : 2'd2, 1'b0);
    end

    // No transfer: grant to id 2 held.
    dn_rdy = 1'b0;
    tick();
    granted("hold1", 2'd2, 1'b0);
    tick();
    granted("hold2", 2'd2, 1'b0);

    // Id 2 aborts while stalled: id 0 takes over at the next edge.
    arb_req = 4'b0001;
    tick();
    granted("abort", 2'd0, 1'b0);
    tick();
    granted("abort_hold", 2'd0, 1'b0);

    // arb_en low: transfer releases into IDLE, pointer kept.
    arb_en = 1'b0;
    dn_rdy = 1'b1;
    tick();
    check("en_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check("en_idle_stay", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Re-enable with req 0110: 1, 2, 1.
    arb_en  = 1'b1;
    arb_req = 4'b0110;
    tick();
    granted("rr_1", 2'd1, 1'b0);
    tick();
    granted("rr_2", 2'd2, 1'b0);
    tick();
    granted("rr_1b", 2'd1, 1'b0);
`endif

    // Asynchronous reset mid-grant drops it without a clock edge.
    arb_req = 4'b1001;
    rst_n   = 1'b0;
    #1;
    check("async_rst", 4'b0000, 1'b0, 2'd3, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    granted("post_rst", 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/arb_rr.md
# arb_rr

Parametrised N-requester round-robin arbiter with registered grant, packet lock and a beat watchdog. It sits in front of a shared output port or link of the network and is the stateful successor of the two-input combinational next-id logic. It keeps the last-winner pointer internally, grants one requester at a time and hands off back-to-back with no bubble cycle. A watchdog forces release of a packet that overruns its beat budget.

## Interface
- `N`, 4: number of requesters, ≥2.
- `MAX_BEATS`, 16: maximum beats per grant before a forced release, ≥2.
- `IDW` (localparam), `$clog2(N)`: width of the id fields.

- `clk`  in  1  clock, all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `arb_en`  in  1  allows new grants; an active grant always runs to release.
- `arb_req`  in  N  per-requester request, level.
- `arb_last`  in  N  per-requester last-beat flag, qualified by transfer.
- `dn_rdy`  in  1  downstream accepts a beat this cycle.
- `arb_gnt`  out  N  one-hot grant, registered; all zero when idle.
- `arb_gnt_vld`  out  1  a grant is active.
- `arb_gnt_id`  out  IDW  current or last winner (the round-robin pointer).
- `arb_err`  out  1  one-cycle pulse on a watchdog-forced release.

## Operation
- Transfer: `xfer = arb_gnt_vld & arb_req[arb_gnt_id] & dn_rdy`.
- Winner function, combinational:
  - Scan `(arb_gnt_id+1) mod N`, `+2`, … , `arb_gnt_id`, and take the first asserted `arb_req` bit.
  - The last winner therefore has the lowest priority.
- States: IDLE and GRANT.
- IDLE:
  - If `arb_en` and `|arb_req`, go to GRANT at the next edge.
  - `arb_gnt_id` ← winner; `arb_gnt` ← onehot(winner); beat counter ← 0.
- GRANT, release when any of these occurs:
  - (a) `xfer & arb_last[arb_gnt_id]`;
  - (b) `arb_req[arb_gnt_id]` is low (requester abort);
  - (c) `xfer` and the beat counter equals `MAX_BEATS-1`; this case also pulses `arb_err`.
- On release:
  - If `arb_en` and the winner exists, stay in GRANT with the new winner, beat counter ← 0.
  - Otherwise go to IDLE: `arb_gnt`=0, `arb_gnt_vld`=0, and `arb_gnt_id` keeps its value.
  - Winner evaluation at release uses the current `arb_req`, including the releasing requester, which ranks lowest.
- No release: the beat counter increments on `xfer` and saturates at `MAX_BEATS-1`.
- `arb_en` low during GRANT: the current grant continues; no new grant is issued after release.
- Simultaneous (a) and (c): the release counts as normal and `arb_err` stays 0.
- Invariant: `arb_gnt` is one-hot or zero and matches `arb_gnt_id` whenever `arb_gnt_vld`=1.
- Reset values:
  - `arb_gnt`=0, `arb_gnt_vld`=0, `arb_err`=0;
  - `arb_gnt_id`=N-1, so requester 0 wins first;
  - state=IDLE, beat counter=0.
  - Reset mid-packet drops the grant immediately, asynchronously.

## Timing
- Request to grant: `arb_req` asserted in cycle t from IDLE gives `arb_gnt` in cycle t+1.
- Handoff: release in cycle t gives the new grant in t+1, with zero bubble cycles.
- Abort, case (b): the grant is removed at the next edge. At most one non-transfer cycle is granted to a dropped requester.
- `arb_err` is high in the cycle after the forced-release edge, for exactly one cycle.
- No combinational path from any input to any output.

## Configuration
- `ARB_RR_PKT_LOCK_EN` defined:
  - Grants are packet-locked; release occurs on (a), (b) or (c) as above.
- `ARB_RR_PKT_LOCK_EN` undefined:
  - Grants are per-beat; every `xfer` is a release, with re-arbitration in the same cycle.
  - `arb_last` is ignored.
  - The watchdog is removed and `arb_err` is tied 0.
  - (b) still applies.

## Test plan
N=4, MAX_BEATS=8, lock enabled unless stated.
- Reset then `arb_req`=4'b1111, `dn_rdy`=1, each packet 2 beats → grants in order 0,1,2,3,0, each held 2 cycles, no idle cycle between them.
- `arb_gnt_id`=1 granted, `arb_req`=4'b1011, last beat sent → next grant id 3, then 0, then 1; id 2 is never granted.
- Grant to id 2 with `dn_rdy`=0 for 5 cycles → grant held, beat counter unchanged; `dn_rdy`=1 with `arb_last` on beat 3 → release after 3 transfers.
- Id 0 sends 8 beats without `arb_last` → forced release after the 8th transfer; `arb_err`=1 for one cycle; id 1 (pending) granted next cycle.
- `arb_en` low mid-packet of id 3 with req 4'b1001 → id 3 finishes its packet, then IDLE with `arb_gnt_id` still 3; `arb_en` high → id 0 granted one cycle later. Then `rst_n` pulsed low mid-packet → `arb_gnt`=0 asynchronously and `arb_gnt_id`=3'd… reset to 3 (N-1).
- Lock disabled, `arb_req`=4'b0101, `dn_rdy`=1 → grants alternate 0,2,0,2 every cycle; `arb_last` values have no effect.
